// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: shared state/direction types for the intersection controller
package traffic_light_pkg;

    typedef enum logic {GREEN, CLEAR} tl_state_e;
    typedef enum logic [1:0] {DIR_A, DIR_B, DIR_C, DIR_D} tl_dir_e;

    localparam int NUM_DIRS = 4;

    function automatic logic [NUM_DIRS-1:0] dir_onehot(tl_dir_e d);
        return NUM_DIRS'(1) << d;
    endfunction

endpackage

// File: rtl/traffic_light_rr_arbiter4.sv
// rr_arbiter4: combinational rotating-priority picker, search starts at base and wraps
module rr_arbiter4
    import traffic_light_pkg::*;
(
    input  logic [NUM_DIRS-1:0] req,
    input  tl_dir_e             base,
    output tl_dir_e             grant,
    output logic                valid
);

    logic [1:0] idx;

    assign valid = |req;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant = base;
        idx   = 2'd0;
        for (int i = NUM_DIRS - 1; i >= 0; i--) begin
            idx = base + 2'(i);
            if (req[idx]) grant = tl_dir_e'(idx);
        end
    end

endmodule

// File: rtl/traffic_light.sv
// traffic_light: four-way green controller with latched requests, round-robin grants
// and an all-red clearance interval between greens.
module traffic_light
    import traffic_light_pkg::*;
#(
    parameter int MIN_GREEN_CYCLES = 4,
    parameter int CLEAR_CYCLES     = 2,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch_to_a,
    input  logic       switch_to_b,
    input  logic       switch_to_c,
    input  logic       switch_to_d,
    output logic [3:0] light_en
);

    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(MIN_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    tl_state_e            state;
    tl_dir_e              cur, target, grant, base;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_DIRS-1:0]  pending, sw, req, cur_oh, tgt_oh;
    logic                 valid;

    assign sw       = {switch_to_d, switch_to_c, switch_to_b, switch_to_a};
    assign cur_oh   = dir_onehot(cur);
    assign tgt_oh   = dir_onehot(target);
    assign req      = (pending | sw) & ~cur_oh;
    assign base     = tl_dir_e'(cur + 2'd1);
    assign light_en = (state == GREEN) ? cur_oh : '0;

    rr_arbiter4 u_arb (
        .req   (req),
        .base  (base),
        .grant (grant),
        .valid (valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= GREEN;
            cur     <= DIR_A;
            target  <= DIR_A;
            cnt     <= '0;
            pending <= '0;
        end else if (state == GREEN) begin
            pending <= pending | (sw & ~cur_oh);
            if (cnt == GREEN_LAST && valid) begin
                state  <= CLEAR;
                target <= grant;
                cnt    <= '0;
            end else if (cnt != GREEN_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            // The old green may be re-requested here; only the chosen target is dropped.
            pending <= (pending | sw) & ~tgt_oh;
            if (cnt == CLEAR_LAST) begin
                state <= GREEN;
                cur   <= target;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_traffic_light.sv
// tb_traffic_light: directed + random switch stimulus checked against a time-based reference model
module tb_traffic_light;

    localparam int MIN   = 4;
    localparam int CLR   = 2;
    localparam int NRAND = 1500;

    logic       clk = 1'b0;
    logic       rst;
    logic       sa, sb, sc, sd;
    logic [3:0] light_en;

    int checks = 0;
    int errors = 0;

    int       m_green, m_gtime, m_ctime, m_target;
    bit       m_clear;
    bit [3:0] m_pend;

    logic [3:0] d_sw  [8] = '{4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b1110, 4'b0000, 4'b0100, 4'b0000};
    int         d_len [8] = '{8, 7, 1, 12, 30, 2, 10, 4};

    always #5 clk = ~clk;

    traffic_light dut (
        .clk         (clk),
        .rst         (rst),
        .switch_to_a (sa),
        .switch_to_b (sb),
        .switch_to_c (sc),
        .switch_to_d (sd),
        .light_en    (light_en)
    );

    always @(negedge clk) assert ($onehot0(light_en)) else $error("light_en not onehot0: %b", light_en);

    task automatic check(string tag, logic [3:0] got, logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_light();
        return m_clear ? 4'b0000 : 4'(1 << m_green);
    endfunction

    task automatic m_reset();
        m_green  = 0;
        m_target = 0;
        m_clear  = 0;
        m_gtime  = 0;
        m_ctime  = 0;
        m_pend   = '0;
    endtask

    // Model: count clocks spent green / red; hand off once MIN clocks of green have elapsed.
    task automatic m_step(logic [3:0] sw);
        if (m_clear) begin
            m_pend |= sw;
            m_pend[m_target] = 1'b0;
            m_ctime++;
            if (m_ctime == CLR) begin
                m_clear = 0;
                m_green = m_target;
                m_gtime = 0;
            end
        end else begin
            m_pend |= sw;
            m_pend[m_green] = 1'b0;
            m_gtime++;
            if (m_gtime >= MIN && m_pend != 0) begin
                for (int k = 3; k >= 1; k--)
                    if (m_pend[(m_green + k) % 4]) m_target = (m_green + k) % 4;
                m_clear = 1;
                m_ctime = 0;
            end
        end
    endtask

    initial begin
        logic [3:0] sw;
        bit         r;
        int         seg, left;
        rst = 1'b1;
        {sd, sc, sb, sa} = 4'b0000;
        m_reset();
        #1 check("reset_async", light_en, 4'b0001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", light_en, 4'b0001);
        rst  = 1'b0;
        seg  = 0;
        left = d_len[0];
        for (int cyc = 0; cyc < NRAND; cyc++) begin
            if (seg < 8) begin
                sw = d_sw[seg];
                r  = 1'b0;
                left--;
                if (left == 0) begin
                    seg++;
                    if (seg < 8) left = d_len[seg];
                end
            end else begin
                for (int i = 0; i < 4; i++) sw[i] = ($urandom_range(0, 5) == 0);
                r = ($urandom_range(0, 39) == 0) || (m_clear && $urandom_range(0, 7) == 0);
            end
            {sd, sc, sb, sa} = sw;
            rst = r;
            if (r) begin
                #1;
                m_reset();
                check("reset_mid", light_en, 4'b0001);
            end
            @(posedge clk);
            if (r) m_reset();
            else m_step(sw);
            @(negedge clk);
            check("light_en", light_en, m_light());
            check("onehot0", 4'($onehot0(light_en)), 4'b0001);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
